// File: rtl/classifier_cfg_ctrl.sv
// Configuration shadow/commit controller and timestamped event log for the seizure classifier.
// Commits are validated, applied atomically, and followed by a classifier restart pulse.
module classifier_cfg_ctrl #(
  parameter int FIFO_DEPTH       = 4,
  parameter int TS_WIDTH         = 16,
  parameter int RST_PULSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_addr,
  input  logic [15:0]         cfg_data,
  output logic [7:0]          class_a_thresh_out,
  output logic [7:0]          class_b_thresh_out,
  output logic [15:0]         timeout_period_out,
  output logic                cls_reset,
  output logic                cfg_error,
  input  logic [1:0]          event_in,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [TS_WIDTH+1:0] evt_data,
  output logic                evt_overflow
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, SETTLE} state_t;

  state_t               state, state_nxt;
  logic                 commit_pend;
  logic [CNT_W-1:0]     pulse_cnt;
  logic [7:0]           shadow_a, shadow_b;
  logic [15:0]          shadow_to;
  logic                 cfg_accept, commit_ok, log_en;

  logic [TS_WIDTH-1:0]  ts;
  logic [1:0]           prev_event;
  logic [TS_WIDTH+1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       fifo_cnt;
  logic                 push, pop, full, wr_en;

  assign cfg_accept = cfg_valid & cfg_ready;
  assign commit_ok  = (shadow_b != 8'd0) && (shadow_a >= shadow_b) && (shadow_to != 16'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (commit_pend) state_nxt = CHECK;
      CHECK:   state_nxt = commit_ok ? APPLY : IDLE;
      APPLY:   if (pulse_cnt == PULSE_LAST) state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A commit is latched for one cycle before CHECK, so the host sees cfg_ready drop at the accept edge.
  always_comb begin
    cfg_ready = (state == IDLE) && !commit_pend;
    cls_reset = (state == APPLY);
    log_en    = (state == IDLE) || (state == CHECK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      commit_pend <= 1'b0;
      pulse_cnt   <= '0;
    end else begin
      if (state == IDLE && commit_pend)
        commit_pend <= 1'b0;
      else if (cfg_accept && cfg_addr == 2'd3)
        commit_pend <= 1'b1;
      pulse_cnt <= (state == APPLY) ? pulse_cnt + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_a           <= 8'd5;
      shadow_b           <= 8'd1;
      shadow_to          <= 16'd10000;
      class_a_thresh_out <= 8'd5;
      class_b_thresh_out <= 8'd1;
      timeout_period_out <= 16'd10000;
      cfg_error          <= 1'b0;
    end else begin
      if (cfg_accept) begin
        case (cfg_addr)
          2'd0:    shadow_a  <= cfg_data[7:0];
          2'd1:    shadow_b  <= cfg_data[7:0];
          2'd2:    shadow_to <= cfg_data;
          default: ;
        endcase
      end
      if (state == CHECK) begin
        cfg_error <= !commit_ok;
        if (commit_ok) begin
          class_a_thresh_out <= shadow_a;
          class_b_thresh_out <= shadow_b;
          timeout_period_out <= shadow_to;
        end
      end
    end
  end

  // Event log: the classifier restarts in C, so prev_event is held at C while it is being reset.
  assign push  = log_en && (event_in != prev_event);
  assign pop   = evt_valid && evt_ready;
  assign full  = (fifo_cnt == DEPTH_C);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts           <= '0;
      prev_event   <= 2'b00;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      ts         <= ts + TS_WIDTH'(1);
      prev_event <= log_en ? event_in : 2'b00;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: ;
      endcase
      // A drop in the same cycle as a successful commit still reports overflow.
      if (state == CHECK && commit_ok) evt_overflow <= 1'b0;
      if (push && full && !pop)        evt_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {event_in, ts};
  end

  assign evt_valid = (fifo_cnt != '0);
  assign evt_data  = mem[rd_ptr];

endmodule

// File: tb/tb_classifier_cfg_ctrl.sv
// Bench for classifier_cfg_ctrl: directed scenarios plus randomized traffic against a latency-based reference model.
module tb_classifier_cfg_ctrl;
  localparam int D   = 4;
  localparam int TSW = 16;
  localparam int R   = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_addr = 2'd0;
  logic [15:0]    cfg_data = 16'd0;
  logic [1:0]     event_in = 2'b00;
  logic           evt_ready = 1'b0;
  logic           cfg_ready, cls_reset, cfg_error, evt_valid, evt_overflow;
  logic [7:0]     class_a_thresh_out, class_b_thresh_out;
  logic [15:0]    timeout_period_out;
  logic [TSW+1:0] evt_data;

  int n_cmp = 0;
  int n_fail = 0;

  classifier_cfg_ctrl #(.FIFO_DEPTH(D), .TS_WIDTH(TSW), .RST_PULSE_CYCLES(R)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .class_a_thresh_out(class_a_thresh_out), .class_b_thresh_out(class_b_thresh_out),
    .timeout_period_out(timeout_period_out), .cls_reset(cls_reset), .cfg_error(cfg_error),
    .event_in(event_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: commit timing derived from the accept edge T (update at T+2, pulse R cycles, settle 1).
  int             cyc = 0;
  int             com_t = -1000;
  bit             com_ok = 1'b0;
  logic [7:0]     m_sh_a, m_sh_b, m_act_a, m_act_b;
  logic [15:0]    m_sh_to, m_act_to;
  bit             m_err, m_ovf;
  logic [1:0]     m_prev;
  logic [TSW-1:0] m_ts;
  logic [TSW+1:0] m_q[$];
  int             e_m;
  bit             pop_m, push_m;

  function automatic bit m_ready(int e);
    if (com_ok) return !(e >= com_t + 1 && e <= com_t + R + 3);
    return !(e >= com_t + 1 && e <= com_t + 2);
  endfunction

  function automatic bit m_logen(int e);
    return !(com_ok && e >= com_t + 3 && e <= com_t + R + 3);
  endfunction

  function automatic bit m_clsrst(int e);
    return com_ok && e >= com_t + 3 && e <= com_t + R + 2;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      com_t = -1000; com_ok = 1'b0;
      m_sh_a = 8'd5; m_sh_b = 8'd1; m_sh_to = 16'd10000;
      m_act_a = 8'd5; m_act_b = 8'd1; m_act_to = 16'd10000;
      m_err = 1'b0; m_ovf = 1'b0; m_prev = 2'b00; m_ts = '0;
      m_q.delete();
    end else begin
      e_m = cyc + 1;
      if (e_m == com_t + 2) begin
        if (com_ok) begin
          m_act_a = m_sh_a; m_act_b = m_sh_b; m_act_to = m_sh_to;
          m_err = 1'b0; m_ovf = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
      pop_m  = (m_q.size() > 0) && (evt_ready === 1'b1);
      push_m = m_logen(e_m) && (event_in !== m_prev);
      if (pop_m) void'(m_q.pop_front());
      if (push_m) begin
        if (m_q.size() < D) m_q.push_back({event_in, m_ts});
        else m_ovf = 1'b1;
      end
      m_prev = m_logen(e_m) ? event_in : 2'b00;
      if (cfg_valid === 1'b1 && m_ready(e_m)) begin
        case (cfg_addr)
          2'd0: m_sh_a = cfg_data[7:0];
          2'd1: m_sh_b = cfg_data[7:0];
          2'd2: m_sh_to = cfg_data;
          default: begin
            com_t = e_m;
            com_ok = (m_sh_b >= 8'd1) && (m_sh_a >= m_sh_b) && (m_sh_to >= 16'd1);
          end
        endcase
      end
      m_ts = m_ts + 1'b1;
      cyc = e_m;
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL cfg_write_wait: cfg_ready=%b after %0d cycles, required 1", cfg_ready, n);
    end
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp += 6;
    if (class_a_thresh_out !== 8'd5) begin n_fail++; $display("FAIL reset_a: got %0d need 5", class_a_thresh_out); end
    if (class_b_thresh_out !== 8'd1) begin n_fail++; $display("FAIL reset_b: got %0d need 1", class_b_thresh_out); end
    if (timeout_period_out !== 16'd10000) begin n_fail++; $display("FAIL reset_to: got %0d need 10000", timeout_period_out); end
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b need 1", cfg_ready); end
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid: got %b need 0", evt_valid); end
    if (cls_reset !== 1'b0 || cfg_error !== 1'b0 || evt_overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: cls_reset=%b cfg_error=%b ovf=%b need 000", cls_reset, cfg_error, evt_overflow);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cfg_ready !== 1'b1 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready=%b evt_valid=%b need 1/0", cfg_ready, evt_valid);
    end
  endtask

  task automatic test_commit();
    int hi = 0;
    int lo = 0;
    cfg_write(2'd0, 16'd8); cfg_write(2'd1, 16'd3); cfg_write(2'd2, 16'd4000);
    n_cmp++;
    if (class_a_thresh_out !== 8'd5) begin n_fail++; $display("FAIL shadow_isolation: a=%0d need 5", class_a_thresh_out); end
    cfg_write(2'd3, 16'd0);
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin
        n_cmp++;
        if (class_a_thresh_out !== 8'd5 || cls_reset !== 1'b0) begin
          n_fail++; $display("FAIL commit_early: a=%0d cls_reset=%b need 5/0 at T+1", class_a_thresh_out, cls_reset);
        end
      end
      if (i == 2) begin
        n_cmp += 2;
        if ({class_a_thresh_out, class_b_thresh_out, timeout_period_out} !== {8'd8, 8'd3, 16'd4000}) begin
          n_fail++; $display("FAIL commit_values: %0d/%0d/%0d need 8/3/4000", class_a_thresh_out, class_b_thresh_out, timeout_period_out);
        end
        if (cls_reset !== 1'b1) begin n_fail++; $display("FAIL commit_pulse_start: cls_reset=%b need 1 at T+2", cls_reset); end
      end
      if (cls_reset === 1'b1) hi++;
      if (cfg_ready === 1'b0) lo++;
      @(negedge clk);
    end
    n_cmp += 3;
    if (hi != R) begin n_fail++; $display("FAIL commit_pulse_len: %0d cycles need %0d", hi, R); end
    if (lo != R + 3) begin n_fail++; $display("FAIL commit_busy_len: %0d cycles need %0d", lo, R + 3); end
    if (cfg_error !== 1'b0) begin n_fail++; $display("FAIL commit_error: got %b need 0", cfg_error); end
  endtask

  task automatic test_reject();
    int seen = 0;
    cfg_write(2'd0, 16'd2);
    cfg_write(2'd3, 16'd0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        n_cmp++;
        if (cfg_error !== 1'b1 || cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL reject_flag: cfg_error=%b ready=%b need 1/1 at T+2", cfg_error, cfg_ready);
        end
      end
      if (cls_reset === 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp += 2;
    if (seen != 0) begin n_fail++; $display("FAIL reject_pulse: cls_reset high %0d cycles need 0", seen); end
    if ({class_a_thresh_out, class_b_thresh_out, timeout_period_out} !== {8'd8, 8'd3, 16'd4000}) begin
      n_fail++; $display("FAIL reject_values: %0d/%0d/%0d need 8/3/4000", class_a_thresh_out, class_b_thresh_out, timeout_period_out);
    end
    cfg_write(2'd0, 16'd3);
    cfg_write(2'd3, 16'd0);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (cfg_error !== 1'b0 || class_a_thresh_out !== 8'd3 || class_b_thresh_out !== 8'd3) begin
      n_fail++; $display("FAIL recover: err=%b a=%0d b=%0d need 0/3/3", cfg_error, class_a_thresh_out, class_b_thresh_out);
    end
  endtask

  task automatic test_overflow();
    logic [1:0]     seq [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [TSW-1:0] ts_prev = '0;
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      event_in = seq[i];
      repeat (2) @(negedge clk);
    end
    n_cmp += 2;
    if (evt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b need 1", evt_overflow); end
    if (m_q.size() != D || evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL ovf_hold: model entries %0d evt_valid=%b need %0d/1", m_q.size(), evt_valid, D);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp += 2;
      if (evt_valid !== 1'b1 || evt_data[TSW+1:TSW] !== seq[i]) begin
        n_fail++; $display("FAIL ovf_pop%0d: valid=%b event=%b need 1/%b", i, evt_valid, evt_data[TSW+1:TSW], seq[i]);
      end
      if (i > 0 && evt_data[TSW-1:0] !== ts_prev + 16'd2) begin
        n_fail++; $display("FAIL ovf_ts%0d: ts=%0d need %0d", i, evt_data[TSW-1:0], ts_prev + 16'd2);
      end
      ts_prev = evt_data[TSW-1:0];
      @(negedge clk);
    end
    evt_ready = 1'b0;
    n_cmp++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: evt_valid=%b need 0", evt_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] last = 2'b00;
    int n = 0;
    cfg_write(2'd3, 16'd0);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL commit_clears_ovf: got %b need 0", evt_overflow); end
    for (int i = 0; i < 4; i++) begin
      event_in = (i % 2 == 0) ? 2'b01 : 2'b00;
      repeat (2) @(negedge clk);
    end
    event_in = 2'b10;
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    n_cmp += 2;
    if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_ovf: got %b need 0", evt_overflow); end
    if (evt_valid !== 1'b1 || evt_data[TSW+1:TSW] !== 2'b00) begin
      n_fail++; $display("FAIL full_pushpop_head: valid=%b event=%b need 1/00", evt_valid, evt_data[TSW+1:TSW]);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid === 1'b1) begin
        last = evt_data[TSW+1:TSW];
        n++;
      end
      @(negedge clk);
    end
    evt_ready = 1'b0;
    n_cmp++;
    if (n != 4 || last !== 2'b10) begin
      n_fail++; $display("FAIL full_pushpop_count: %0d entries last=%b need 4/10", n, last);
    end
  endtask

  task automatic test_apply_events();
    int  n = 0;
    bit  leaked = 1'b0;
    event_in = 2'b00;
    repeat (2) @(negedge clk);
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    evt_ready = 1'b0;
    cfg_write(2'd0, 16'd7);
    cfg_write(2'd3, 16'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cls_reset !== 1'b1) begin n_fail++; $display("FAIL apply_pulse: cls_reset=%b need 1", cls_reset); end
    event_in = 2'b10;
    @(negedge clk);
    event_in = 2'b01;
    while (cfg_ready !== 1'b1 && n < 20) begin
      if (evt_valid !== 1'b0) leaked = 1'b1;
      @(negedge clk);
      n++;
    end
    n_cmp += 3;
    if (n >= 20) begin n_fail++; $display("FAIL apply_timeout: cfg_ready=%b need 1", cfg_ready); end
    if (leaked || evt_valid !== 1'b0) begin n_fail++; $display("FAIL apply_no_log: evt_valid=%b need 0", evt_valid); end
    if (class_a_thresh_out !== 8'd7) begin n_fail++; $display("FAIL apply_value: a=%0d need 7", class_a_thresh_out); end
    @(negedge clk);
    n_cmp++;
    if (evt_valid !== 1'b1 || evt_data[TSW+1:TSW] !== 2'b01) begin
      n_fail++; $display("FAIL settle_log: valid=%b event=%b need 1/01", evt_valid, evt_data[TSW+1:TSW]);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    event_in = 2'b00;
    cfg_write(2'd0, 16'd9);
    cfg_write(2'd3, 16'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cls_reset !== 1'b1) begin n_fail++; $display("FAIL abort_pulse: cls_reset=%b need 1", cls_reset); end
    #2 reset = 1'b1;
    #1;
    n_cmp += 2;
    if (cls_reset !== 1'b0 || cfg_ready !== 1'b1 || evt_valid !== 1'b0 || cfg_error !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl: cls_reset=%b ready=%b evt_valid=%b err=%b need 0/1/0/0", cls_reset, cfg_ready, evt_valid, cfg_error);
    end
    if ({class_a_thresh_out, class_b_thresh_out, timeout_period_out} !== {8'd5, 8'd1, 16'd10000}) begin
      n_fail++; $display("FAIL abort_values: %0d/%0d/%0d need 5/1/10000", class_a_thresh_out, class_b_thresh_out, timeout_period_out);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      n_cmp += 6;
      if (cfg_ready !== m_ready(cyc + 1)) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b need %b", i, cfg_ready, m_ready(cyc + 1)); end
      if (cls_reset !== m_clsrst(cyc + 1)) begin n_fail++; $display("FAIL rnd_cls_reset@%0d: got %b need %b", i, cls_reset, m_clsrst(cyc + 1)); end
      if ({class_a_thresh_out, class_b_thresh_out, timeout_period_out} !== {m_act_a, m_act_b, m_act_to}) begin
        n_fail++; $display("FAIL rnd_active@%0d: %0d/%0d/%0d need %0d/%0d/%0d", i, class_a_thresh_out, class_b_thresh_out,
                           timeout_period_out, m_act_a, m_act_b, m_act_to);
      end
      if (cfg_error !== m_err || evt_overflow !== m_ovf) begin
        n_fail++; $display("FAIL rnd_flags@%0d: err=%b ovf=%b need %b/%b", i, cfg_error, evt_overflow, m_err, m_ovf);
      end
      if (evt_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_evt_valid@%0d: got %b need %0d", i, evt_valid, m_q.size() > 0); end
      if (m_q.size() > 0 && evt_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_evt_data@%0d: got %h need %h", i, evt_data, m_q[0]); end
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_addr  = 2'($urandom_range(0, 3));
      cfg_data  = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) event_in = 2'($urandom_range(0, 3));
      evt_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    evt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_reject();
    test_overflow();
    test_full_push_pop();
    test_apply_events();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
